// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker
// Description : Receiving end of a free-running up-counter's `count` bus.
//               Each enabled cycle the sampled value is checked to advance by
//               exactly +1 modulo 2^Size. Tracks lock state, mismatches and
//               wrap-arounds, reporting through flags and saturating counters.
//
// Ports       : clock        - design clock, rising edge
//               reset        - asynchronous, active-high reset
//               enable       - `count` is valid this cycle and is checked
//               count        - observed counter value [Size-1:0]
//               clear        - synchronous clear of err_count, wraps and
//                              error_sticky (state machine unaffected)
//               locked       - high while in LOCKED
//               error        - registered one-cycle pulse per mismatch
//               error_sticky - set on first mismatch, held until clear/reset
//               err_count    - saturating mismatch counter [ErrWidth-1:0]
//               wraps        - saturating max->0 transition counter
//
// Options     : COUNTER_CHECKER_HOLD_EN - when defined, a repeated value
//               (count == expected-1) in RESYNC/LOCKED is accepted silently.
//
// Revision    : 1.0 - initial release
// ============================================================================
module counter_checker #(
  parameter int Size     = 5,
  parameter int ErrWidth = 8,
  parameter int LockRun  = 2   // legal range 1..15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [Size-1:0]     count,
  input  logic                clear,
  output logic                locked,
  output logic                error,
  output logic                error_sticky,
  output logic [ErrWidth-1:0] err_count,
  output logic [ErrWidth-1:0] wraps
);

  localparam logic [1:0] c_unsync = 2'd0;
  localparam logic [1:0] c_resync = 2'd1;
  localparam logic [1:0] c_locked = 2'd2;

  localparam logic [3:0] c_lock_run = LockRun[3:0];

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [Size-1:0]     r_expected;
  logic [Size-1:0]     w_expected_next;
  logic [3:0]          r_run;
  logic [3:0]          w_run_next;
  logic                r_error;
  logic                r_error_sticky;
  logic [ErrWidth-1:0] r_err_count;
  logic [ErrWidth-1:0] r_wraps;

  logic [Size-1:0]     w_count_inc;
  logic [3:0]          w_run_inc;
  logic                w_match;
  logic                w_hold;
  logic                w_err_evt;
  logic                w_wrap_evt;

  assign w_count_inc = count + 1'b1;
  assign w_run_inc   = r_run + 4'd1;
  assign w_match     = (count == r_expected);

`ifdef COUNTER_CHECKER_HOLD_EN
  // A counter that stalls for a cycle re-presents the previous value.
  logic [Size-1:0] w_expected_dec;
  assign w_expected_dec = r_expected - 1'b1;
  assign w_hold         = (count == w_expected_dec);
`else
  assign w_hold = 1'b0;
`endif

  // Only a mismatch while LOCKED is an error; RESYNC mismatches just restart.
  assign w_err_evt  = enable && (r_state == c_locked) && !w_match && !w_hold;
  // expected==0 on a match means the previous sample was all-ones.
  assign w_wrap_evt = enable && (r_state != c_unsync) && w_match &&
                      (r_expected == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= c_unsync;
      r_expected <= '0;
      r_run      <= 4'd0;
    end else if (enable) begin
      r_state    <= w_state_next;
      r_expected <= w_expected_next;
      r_run      <= w_run_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_expected_next = r_expected;
    w_run_next      = r_run;
    case (r_state)
      c_unsync: begin
        w_expected_next = w_count_inc;
        w_run_next      = 4'd1;
        w_state_next    = (c_lock_run == 4'd1) ? c_locked : c_resync;
      end
      c_resync: begin
        if (w_match) begin
          w_expected_next = w_count_inc;
          w_run_next      = w_run_inc;
          if (w_run_inc >= c_lock_run) begin
            w_state_next = c_locked;
          end
        end else if (!w_hold) begin
          w_expected_next = w_count_inc;
          w_run_next      = 4'd1;
        end
      end
      c_locked: begin
        if (w_match) begin
          w_expected_next = w_count_inc;
        end else if (!w_hold) begin
          w_expected_next = w_count_inc;
          w_run_next      = 4'd1;
          w_state_next    = c_resync;
        end
      end
      default: begin
        w_state_next = c_unsync;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Error flags and statistics. clear takes priority over a same-cycle event,
  // but the error pulse itself is never suppressed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_error        <= 1'b0;
      r_error_sticky <= 1'b0;
      r_err_count    <= '0;
      r_wraps        <= '0;
    end else begin
      r_error <= w_err_evt;
      if (clear) begin
        r_error_sticky <= 1'b0;
        r_err_count    <= '0;
        r_wraps        <= '0;
      end else begin
        if (w_err_evt) begin
          r_error_sticky <= 1'b1;
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + 1'b1;
          end
        end
        if (w_wrap_evt && (r_wraps != '1)) begin
          r_wraps <= r_wraps + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    locked       = (r_state == c_locked);
    error        = r_error;
    error_sticky = r_error_sticky;
    err_count    = r_err_count;
    wraps        = r_wraps;
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_checker
// Description : Directed self-checking bench for counter_checker
//               (Size=5, ErrWidth=8, LockRun=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_checker;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [4:0] count;
  logic       clear;
  logic       locked;
  logic       error;
  logic       error_sticky;
  logic [7:0] err_count;
  logic [7:0] wraps;

  int n_vec;
  int n_miss;

  counter_checker #(
    .Size     (5),
    .ErrWidth (8),
    .LockRun  (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .count        (count),
    .clear        (clear),
    .locked       (locked),
    .error        (error),
    .error_sticky (error_sticky),
    .err_count    (err_count),
    .wraps        (wraps)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample, let it be registered, then look just after the edge.
  task automatic step(input logic en, input logic [4:0] cnt, input logic clr);
    enable = en;
    count  = cnt;
    clear  = clr;
    @(posedge clock);
    #1;
    enable = 1'b0;
    clear  = 1'b0;
  endtask

  logic [4:0] e;
  logic [4:0] m;
  logic [7:0] wrap_model;
  logic [31:0] hold_err;

  initial begin
    n_vec  = 0;
    n_miss = 0;
`ifdef COUNTER_CHECKER_HOLD_EN
    hold_err = 32'd0;
`else
    hold_err = 32'd1;
`endif
    enable = 1'b0;
    count  = 5'd0;
    clear  = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_locked", locked, 0);
    check("rst_error", error, 0);
    check("rst_sticky", error_sticky, 0);
    check("rst_errcnt", err_count, 0);
    check("rst_wraps", wraps, 0);
    reset = 1'b0;

    // Acquire lock: 0 -> RESYNC, 1 -> LOCKED.
    step(1'b1, 5'd0, 1'b0);
    check("acq_locked0", locked, 0);
    step(1'b1, 5'd1, 1'b0);
    check("acq_locked1", locked, 1);
    check("acq_error1", error, 0);
    step(1'b1, 5'd2, 1'b0);
    step(1'b1, 5'd3, 1'b0);
    check("acq_locked3", locked, 1);
    check("acq_errcnt", err_count, 0);

    // Count up through the wrap.
    for (int i = 4; i <= 28; i++) step(1'b1, 5'(i), 1'b0);
    step(1'b1, 5'd29, 1'b0);
    step(1'b1, 5'd30, 1'b0);
    step(1'b1, 5'd31, 1'b0);
    check("wrap_pre", wraps, 0);
    step(1'b1, 5'd0, 1'b0);
    check("wrap_cnt", wraps, 1);
    step(1'b1, 5'd1, 1'b0);
    check("wrap_cnt2", wraps, 1);
    check("wrap_locked", locked, 1);
    check("wrap_error", error, 0);
    check("wrap_errcnt", err_count, 0);

    // Mismatch at expected=6.
    for (int i = 2; i <= 5; i++) step(1'b1, 5'(i), 1'b0);
    step(1'b1, 5'd9, 1'b0);
    check("mis_error", error, 1);
    check("mis_sticky", error_sticky, 1);
    check("mis_errcnt", err_count, 1);
    check("mis_locked", locked, 0);
    step(1'b1, 5'd10, 1'b0);
    check("relock_error", error, 0);
    check("relock_locked", locked, 1);
    step(1'b1, 5'd11, 1'b0);
    check("relock_locked2", locked, 1);
    check("relock_errcnt", err_count, 1);
    e = 5'd12;

    // Saturation: mismatch, relock, repeated 256 times.
    wrap_model = 8'd1;
    for (int i = 0; i < 256; i++) begin
      m = e + 5'd3;
      step(1'b1, m, 1'b0);
      check("sat_error", error, 1);
      e = m + 5'd1;
      step(1'b1, e, 1'b0);
      if (e == 5'd0 && wrap_model != 8'hff) wrap_model = wrap_model + 8'd1;
      e = e + 5'd1;
    end
    check("sat_errcnt", err_count, 255);
    check("sat_wraps", wraps, 32'(wrap_model));
    check("sat_locked", locked, 1);

    // Clear with no event.
    step(1'b0, 5'd0, 1'b1);
    check("clr_errcnt", err_count, 0);
    check("clr_wraps", wraps, 0);
    check("clr_sticky", error_sticky, 0);
    check("clr_locked", locked, 1);

    // Clear coinciding with a mismatch: clear wins, pulse still fires.
    step(1'b1, e + 5'd3, 1'b1);
    check("clrev_error", error, 1);
    check("clrev_errcnt", err_count, 0);
    check("clrev_sticky", error_sticky, 0);
    check("clrev_locked", locked, 0);
    e = e + 5'd4;
    step(1'b1, e, 1'b0);
    check("clrev_relock", locked, 1);
    e = e + 5'd1;

    // Disabled cycles with arbitrary count.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 5'($urandom_range(0, 31)), 1'b0);
      check("dis_locked", locked, 1);
      check("dis_error", error, 0);
    end
    step(1'b1, e, 1'b0);
    check("dis_resume_locked", locked, 1);
    check("dis_resume_error", error, 0);
    check("dis_resume_errcnt", err_count, 0);
    e = e + 5'd1;

    // Make some state non-zero, then reset asynchronously between edges.
    step(1'b1, e + 5'd3, 1'b0);
    check("pre_rst_errcnt", err_count, 1);
    e = e + 5'd4;
    step(1'b1, e, 1'b0);
    check("pre_rst_locked", locked, 1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("arst_locked", locked, 0);
    check("arst_error", error, 0);
    check("arst_sticky", error_sticky, 0);
    check("arst_errcnt", err_count, 0);
    check("arst_wraps", wraps, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Restart from UNSYNC, then held-value stimulus 7,7,8.
    step(1'b1, 5'd5, 1'b0);
    check("rs_locked0", locked, 0);
    step(1'b1, 5'd6, 1'b0);
    check("rs_locked1", locked, 1);
    step(1'b1, 5'd7, 1'b0);
    check("hold_first_error", error, 0);
    step(1'b1, 5'd7, 1'b0);
    check("hold_repeat_error", error, hold_err);
    step(1'b1, 5'd8, 1'b0);
    check("hold_after_error", error, 0);
    check("hold_after_locked", locked, 1);
    check("hold_errcnt", err_count, hold_err);
    check("hold_sticky", error_sticky, hold_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receiving end of the counter's `count` output.
- Samples a free-running up-counter's `count` bus each enabled clock and checks it advances by exactly +1 modulo 2^Size.
- Tracks lock state, mismatches and wrap-arounds.
- Sits beside a `counter` instance in benches and in on-chip self-test; reports through flags and saturating statistics counters.

Parameters:
- Size, 5, width of the observed `count` bus; must match the counter instance.
- ErrWidth, 8, width of the `err_count` and `wraps` statistics counters.
- LockRun, 2, consecutive correct samples required to enter LOCKED from RESYNC; legal range 1..15.

Ports:
- clock  input  1  design clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  `count` is valid this cycle and must be checked.
- count  input  Size  observed counter value.
- clear  input  1  synchronous clear of `err_count`, `wraps` and `error_sticky`; state machine unaffected.
- locked  output  1  high while in LOCKED.
- error  output  1  one-cycle pulse, registered, on each mismatch.
- error_sticky  output  1  set on the first mismatch, held until `clear` or `reset`.
- err_count  output  ErrWidth  number of mismatches, saturating.
- wraps  output  ErrWidth  number of checked transitions max→0, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - state=UNSYNC, expected=0, run=0.
  - All outputs 0.
- All state updates happen on rising `clock` and only when `enable`=1; with `enable`=0 everything holds (except `clear`, and `error` returns to 0).
- `expected` is Size bits; `expected = count + 1` truncated to Size bits, so max+1 → 0.
- UNSYNC:
  - First enabled sample sets expected=count+1 and run=1.
  - Go to LOCKED if LockRun==1, else to RESYNC.
  - No check is performed.
- RESYNC:
  - Match (count==expected): run++, expected=count+1; enter LOCKED when run reaches LockRun.
  - Mismatch: run=1, expected=count+1; no `error` pulse.
- LOCKED:
  - Match: expected=count+1.
  - Mismatch:
    - `error`=1 next cycle.
    - error_sticky=1.
    - err_count++ (saturating at all-ones).
    - expected=count+1, run=1, state=RESYNC.
    - `locked` drops in the same cycle `error` rises.
- Wrap detection:
  - In RESYNC and LOCKED, an enabled match where expected==0 (previous sample = 2^Size-1) increments `wraps` (saturating).
  - Counted in RESYNC too.
- Latency: all outputs are registered, one cycle after the sampled `count`.
- `clear` and event in the same cycle: `clear` wins; the counters become 0, not 1. `error` still pulses, and error_sticky is 0 afterwards.
- Reset mid-operation: immediate return to the reset values; the next enabled sample restarts from UNSYNC.
- Counter reset in the middle of the sequence (count jumps to 0): treated as a mismatch in LOCKED, unless expected was 0, in which case it is a match and a wrap.

Optional Feature:
- Macro: COUNTER_CHECKER_HOLD_EN.
- Defined:
  - In RESYNC and LOCKED, an enabled sample with count==expected-1 (counter held) is accepted.
  - No error, expected unchanged, run unchanged, no wrap counted.
- Not defined: a held value is an ordinary mismatch.

Test Plan:
- Reset, then enable with count 0,1,2,3 (Size=5, LockRun=2) → locked=1 the cycle after the sample `1` is registered; error=0, err_count=0.
- Locked; drive 29,30,31,0,1 → wraps=1, no error, locked stays 1.
- Locked at expected=6; drive 9 → error pulses for one cycle, error_sticky=1, err_count=1, locked=0. Then drive 10,11 → locked=1 again with no further error.
- Force 256 mismatches with ErrWidth=8 → err_count saturates at 255. Then clear=1 for one cycle → err_count=0, wraps=0, error_sticky=0, locked unaffected.
- Locked; enable=0 for 10 cycles while count changes arbitrarily → no state change, no error. Resume with the correct expected value → still locked.
- Assert reset asynchronously mid-run, between clock edges → all outputs 0 immediately.
- HOLD_EN build: locked, drive 7,7,8 → no error. Non-HOLD build: same stimulus → error pulses once and err_count=1.
